ysyx_22040237_exu_ctrl: RTL and testbench

Sequencing controller for the single-cycle EXU. It accepts one decoded instruction at a time from the IDU over a valid/ready handshake, holds it stable while the EXU (single cycle) or an attached multi-cycle unit (MDU) produces the result, and registers that result toward the WBU. It also issues PC redirects for taken jumps and branches, and halts the core on `ebreak`, an invalid instruction, or an MDU timeout.

---
 rtl/ysyx_22040237_exu_ctrl_pkg.sv | 20 ++
 rtl/ysyx_22040237_exu_wdog.sv | 19 +
 rtl/ysyx_22040237_exu_ctrl.sv | 100 ++++++++++
 tb/tb_ysyx_22040237_exu_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040237_exu_ctrl_pkg.sv
// ysyx_22040237_exu_ctrl_pkg: shared EXU info-bus fields, halt causes and controller state encoding
package ysyx_22040237_exu_ctrl_pkg;
  localparam int EXU_INFO_W = 15;
  localparam logic [2:0] EXU_INFO_ALU = 3'd1;
  localparam logic [2:0] EXU_INFO_BJP = 3'd2;
  localparam logic [2:0] EXU_INFO_MDU = 3'd4;
  localparam int EXU_INFO_ALU_EBREAK = 14;
  localparam logic [1:0] HALT_NONE = 2'd0;
  localparam logic [1:0] HALT_EBREAK = 2'd1;
  localparam logic [1:0] HALT_INVALID = 2'd2;
  localparam logic [1:0] HALT_MDU_TO = 2'd3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXEC = 3'd1;
  localparam logic [2:0] ST_MDU_WAIT = 3'd2;
  localparam logic [2:0] ST_WB = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;
  function automatic logic [2:0] exu_grp(input logic [EXU_INFO_W-1:0] info);
    return info[2:0];
  endfunction
endpackage

// File: rtl/ysyx_22040237_exu_wdog.sv
// ysyx_22040237_exu_wdog: 8-bit clear/enable cycle counter flagging MDU_TIMEOUT-1
module ysyx_22040237_exu_wdog #(
  parameter int MDU_TIMEOUT = 70
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [7:0] TC_VAL = 8'(MDU_TIMEOUT - 1);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  end
  assign tc = cnt == TC_VAL;
endmodule

// File: rtl/ysyx_22040237_exu_ctrl.sv
// ysyx_22040237_exu_ctrl: IDU->EXU/MDU->WBU sequencing, PC redirect and halt control
module ysyx_22040237_exu_ctrl
  import ysyx_22040237_exu_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = 70
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic                  id_rd_wr_en_i,
  input  logic [4:0]            id_rd_idx_i,
  input  logic [EXU_INFO_W-1:0] id_exu_info_bus_i,
  input  logic                  id_invalid_inst_i,
  output logic [EXU_INFO_W-1:0] exu_info_bus_o,
  output logic                  exu_rd_wr_en_o,
  output logic [4:0]            exu_rd_idx_o,
  input  logic [63:0]           alu_res_i,
  input  logic                  pc_jump_flag_i,
  input  logic [63:0]           pc_jump_addr_i,
  output logic                  mdu_start_o,
  input  logic                  mdu_done_i,
  input  logic [63:0]           mdu_res_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic                  wb_rd_wr_en_o,
  output logic [4:0]            wb_rd_idx_o,
  output logic [63:0]           wb_data_o,
  output logic                  redirect_valid_o,
  output logic [63:0]           redirect_pc_o,
  output logic                  halt_o,
  output logic [1:0]            halt_cause_o
);
  logic [2:0] state, nxt;
  logic [1:0] cause_nxt;
  logic tc, to_wb;
  ysyx_22040237_exu_wdog #(.MDU_TIMEOUT(MDU_TIMEOUT)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(state != ST_MDU_WAIT),
    .en (state == ST_MDU_WAIT),
    .tc (tc)
  );
  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE: nxt = !id_valid_i ? ST_IDLE
                   : (id_invalid_inst_i || id_exu_info_bus_i[EXU_INFO_ALU_EBREAK]) ? ST_HALT
                   : exu_grp(id_exu_info_bus_i) == EXU_INFO_MDU ? ST_MDU_WAIT : ST_EXEC;
      ST_EXEC: nxt = ST_WB;
      ST_MDU_WAIT: nxt = mdu_done_i ? ST_WB : tc ? ST_HALT : ST_MDU_WAIT;
      ST_WB: nxt = wb_ready_i ? ST_IDLE : ST_WB;
      ST_HALT: nxt = ST_HALT;
      default: nxt = ST_IDLE;
    endcase
  end
  assign cause_nxt = state == ST_MDU_WAIT ? HALT_MDU_TO : id_invalid_inst_i ? HALT_INVALID : HALT_EBREAK;
  assign to_wb = nxt == ST_WB && state != ST_WB;
  assign id_ready_o = state == ST_IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      exu_info_bus_o <= '0;
      exu_rd_wr_en_o <= 1'b0;
      exu_rd_idx_o <= '0;
      mdu_start_o <= 1'b0;
      wb_valid_o <= 1'b0;
      wb_rd_wr_en_o <= 1'b0;
      wb_rd_idx_o <= '0;
      wb_data_o <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o <= '0;
      halt_o <= 1'b0;
      halt_cause_o <= HALT_NONE;
    end else begin
      state <= nxt;
      mdu_start_o <= state == ST_IDLE && nxt == ST_MDU_WAIT;
      wb_valid_o <= nxt == ST_WB;
      halt_o <= nxt == ST_HALT;
      if (state == ST_IDLE && id_valid_i) begin
        exu_info_bus_o <= id_exu_info_bus_i;
        exu_rd_wr_en_o <= id_rd_wr_en_i;
        exu_rd_idx_o <= id_rd_idx_i;
      end
      if (state == ST_EXEC) wb_data_o <= alu_res_i;
      if (state == ST_MDU_WAIT && mdu_done_i) wb_data_o <= mdu_res_i;
      // redirect is armed in EXEC so it becomes visible on the first WB cycle only
      if (state == ST_EXEC && exu_grp(exu_info_bus_o) == EXU_INFO_BJP && pc_jump_flag_i) begin
        redirect_pc_o <= pc_jump_addr_i;
        redirect_valid_o <= 1'b1;
      end
      if (state == ST_WB) redirect_valid_o <= 1'b0;
      if (to_wb) begin
        wb_rd_wr_en_o <= exu_rd_wr_en_o && exu_rd_idx_o != 5'd0;
        wb_rd_idx_o <= exu_rd_idx_o;
      end
      if (nxt == ST_HALT && state != ST_HALT) halt_cause_o <= cause_nxt;
    end
  end
endmodule

// File: tb/tb_ysyx_22040237_exu_ctrl.sv
// tb_ysyx_22040237_exu_ctrl: directed vectors for the EXU sequencing controller
module tb_ysyx_22040237_exu_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic id_valid_i = 0, id_ready_o, id_rd_wr_en_i = 0, id_invalid_inst_i = 0;
  logic [4:0] id_rd_idx_i = 0, exu_rd_idx_o, wb_rd_idx_o;
  logic [14:0] id_exu_info_bus_i = 0, exu_info_bus_o;
  logic exu_rd_wr_en_o, pc_jump_flag_i = 0, mdu_start_o, mdu_done_i = 0;
  logic [63:0] alu_res_i = 0, pc_jump_addr_i = 0, mdu_res_i = 0, wb_data_o, redirect_pc_o;
  logic wb_valid_o, wb_ready_i = 0, wb_rd_wr_en_o, redirect_valid_o, halt_o;
  logic [1:0] halt_cause_o;
  int n_vec = 0, n_err = 0, starts;
  ysyx_22040237_exu_ctrl #(.MDU_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_rd_wr_en_i(id_rd_wr_en_i), .id_rd_idx_i(id_rd_idx_i),
    .id_exu_info_bus_i(id_exu_info_bus_i), .id_invalid_inst_i(id_invalid_inst_i),
    .exu_info_bus_o(exu_info_bus_o), .exu_rd_wr_en_o(exu_rd_wr_en_o), .exu_rd_idx_o(exu_rd_idx_o),
    .alu_res_i(alu_res_i), .pc_jump_flag_i(pc_jump_flag_i), .pc_jump_addr_i(pc_jump_addr_i),
    .mdu_start_o(mdu_start_o), .mdu_done_i(mdu_done_i), .mdu_res_i(mdu_res_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_wr_en_o(wb_rd_wr_en_o),
    .wb_rd_idx_o(wb_rd_idx_o), .wb_data_o(wb_data_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .halt_o(halt_o), .halt_cause_o(halt_cause_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [14:0] info, input logic we, input logic [4:0] rd, input logic inval);
    id_exu_info_bus_i = info;
    id_rd_wr_en_i = we;
    id_rd_idx_i = rd;
    id_invalid_inst_i = inval;
    id_valid_i = 1;
    step();
    id_valid_i = 0;
    id_invalid_inst_i = 0;
  endtask
  task automatic do_reset();
    #2 rst = 0;
    #1;
    chk("rst_mdu_start", mdu_start_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_redirect", redirect_valid_o, 0);
    chk("rst_halt", halt_o, 0);
    chk("rst_id_ready", id_ready_o, 1);
    step();
    rst = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    step();
    step();
    chk("reset_id_ready", id_ready_o, 1);
    chk("reset_wb_valid", wb_valid_o, 0);
    chk("reset_halt", {halt_o, halt_cause_o}, 0);
    chk("reset_exu_info", exu_info_bus_o, 0);
    chk("reset_wb_data", wb_data_o, 0);
    rst = 1;
    step();
    // ALU add x5 = 0x10
    alu_res_i = 64'h10;
    wb_ready_i = 1;
    issue(15'h0001, 1, 5'd5, 0);
    chk("alu_exec_no_valid", wb_valid_o, 0);
    chk("alu_exec_id_ready", id_ready_o, 0);
    chk("alu_exu_rd", exu_rd_idx_o, 5);
    step();
    chk("alu_wb_valid", wb_valid_o, 1);
    chk("alu_wb_data", wb_data_o, 64'h10);
    chk("alu_wb_rd", wb_rd_idx_o, 5);
    chk("alu_wb_we", wb_rd_wr_en_o, 1);
    chk("alu_no_redirect", redirect_valid_o, 0);
    step();
    chk("alu_back_idle", {wb_valid_o, id_ready_o}, 2'b01);
    // write to x0 is suppressed
    alu_res_i = 64'h77;
    issue(15'h0001, 1, 5'd0, 0);
    step();
    chk("x0_wb_we", wb_rd_wr_en_o, 0);
    chk("x0_wb_data", wb_data_o, 64'h77);
    step();
    // taken BEQ
    pc_jump_flag_i = 1;
    pc_jump_addr_i = 64'h8000_0040;
    issue(15'h0002, 0, 5'd0, 0);
    chk("beq_exec_no_redirect", redirect_valid_o, 0);
    step();
    chk("beq_redirect_valid", redirect_valid_o, 1);
    chk("beq_redirect_pc", redirect_pc_o, 64'h8000_0040);
    chk("beq_wb_valid", wb_valid_o, 1);
    step();
    chk("beq_redirect_pulse", redirect_valid_o, 0);
    // not-taken BEQ
    pc_jump_flag_i = 0;
    pc_jump_addr_i = 64'h8000_0080;
    issue(15'h0002, 0, 5'd0, 0);
    step();
    chk("bne_no_redirect", redirect_valid_o, 0);
    chk("bne_wb_valid", wb_valid_o, 1);
    step();
    chk("bne_no_redirect_after", redirect_valid_o, 0);
    // MDU op, done after 5 cycles, WBU stalls 3 cycles
    wb_ready_i = 0;
    issue(15'h0004, 1, 5'd7, 0);
    starts = 0;
    starts += int'(mdu_start_o);
    for (int i = 0; i < 4; i++) begin
      step();
      starts += int'(mdu_start_o);
      chk("mdu_wait_no_valid", wb_valid_o, 0);
    end
    mdu_done_i = 1;
    mdu_res_i = 64'h2A;
    step();
    mdu_done_i = 0;
    mdu_res_i = 64'hDEAD;
    chk("mdu_start_once", starts, 1);
    chk("mdu_wb_valid", wb_valid_o, 1);
    chk("mdu_wb_data", wb_data_o, 64'h2A);
    chk("mdu_wb_rd", wb_rd_idx_o, 7);
    id_valid_i = 1;
    id_rd_idx_i = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", wb_valid_o, 1);
      chk("stall_data", wb_data_o, 64'h2A);
      chk("stall_rd", {wb_rd_wr_en_o, wb_rd_idx_o}, {1'b1, 5'd7});
      chk("stall_id_ready", id_ready_o, 0);
      chk("stall_exu_rd", exu_rd_idx_o, 7);
    end
    id_valid_i = 0;
    wb_ready_i = 1;
    step();
    chk("mdu_back_idle", {wb_valid_o, id_ready_o}, 2'b01);
    // MDU done on the 8th wait cycle still completes
    issue(15'h0004, 1, 5'd8, 0);
    for (int i = 0; i < 7; i++) step();
    chk("mdu8_no_halt", halt_o, 0);
    mdu_done_i = 1;
    mdu_res_i = 64'h55;
    step();
    mdu_done_i = 0;
    chk("mdu8_wb_valid", wb_valid_o, 1);
    chk("mdu8_wb_data", wb_data_o, 64'h55);
    chk("mdu8_no_halt_wb", halt_o, 0);
    step();
    // MDU timeout
    issue(15'h0004, 1, 5'd8, 0);
    for (int i = 0; i < 7; i++) step();
    chk("mdu_to_before", halt_o, 0);
    step();
    chk("mdu_to_halt", halt_o, 1);
    chk("mdu_to_cause", halt_cause_o, 3);
    chk("mdu_to_wb_valid", wb_valid_o, 0);
    chk("mdu_to_id_ready", id_ready_o, 0);
    do_reset();
    // ebreak then a later invalid instruction
    issue(15'h4001, 0, 5'd0, 0);
    chk("ebreak_halt", halt_o, 1);
    chk("ebreak_cause", halt_cause_o, 1);
    issue(15'h0001, 1, 5'd9, 1);
    step();
    chk("ebreak_sticky", {halt_o, halt_cause_o}, {1'b1, 2'd1});
    chk("ebreak_ignored_rd", exu_rd_idx_o, 0);
    do_reset();
    issue(15'h0001, 1, 5'd4, 1);
    chk("invalid_cause", {halt_o, halt_cause_o}, {1'b1, 2'd2});
    do_reset();
    issue(15'h4001, 1, 5'd4, 1);
    chk("invalid_over_ebreak", {halt_o, halt_cause_o}, {1'b1, 2'd2});
    do_reset();
    // asynchronous reset in the middle of MDU_WAIT
    issue(15'h0004, 1, 5'd6, 0);
    chk("mdu_mid_start", mdu_start_o, 1);
    do_reset();
    chk("post_rst_exu_info", exu_info_bus_o, 0);
    alu_res_i = 64'h99;
    issue(15'h0001, 1, 5'd3, 0);
    step();
    chk("post_rst_wb_valid", wb_valid_o, 1);
    chk("post_rst_wb_data", wb_data_o, 64'h99);
    chk("post_rst_wb_rd", {wb_rd_wr_en_o, wb_rd_idx_o}, {1'b1, 5'd3});
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
